ssd1306_i2c_sequencer: RTL and testbench
========================================

Name: ssd1306_i2c_sequencer

Overview:
- Controller that sequences the multi-byte write-only I2C master for a 128x64 SSD1306 OLED.
- After a power-up delay it sends the fixed display init sequence. It then serves refresh requests.
- Each refresh is two I2C transactions: a window-set command transaction, then a 1024-byte GDDRAM data stream read from an external framebuffer RAM.
- Sits between the display top level and the I2C master. It drives the master's start/stop/data_valid/data_in and consumes its data_req/busy.

Parameters:
- CLK_FREQ, 27_000_000, system clock in Hz.
- POWERUP_US, 100_000, delay after reset before the init transaction; POWERUP_CYCLES = CLK_FREQ/1_000_000*POWERUP_US.
- SLAVE_ADDR, 7'h3C, 7-bit I2C address. The address byte sent is {SLAVE_ADDR,1'b0} = 8'h78.
- FB_BYTES, 1024, bytes per full-frame data transaction.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- refresh  in  1  1-cycle pulse: request a full-frame update
- fb_addr  out  10  framebuffer read address (page*128+column)
- fb_rd  out  1  framebuffer read strobe; fb_data is valid exactly 1 cycle later
- fb_data  in  8  framebuffer read data
- m_start  out  1  to master start
- m_stop  out  1  to master stop
- m_data_valid  out  1  to master data_valid
- m_data_in  out  8  to master data_in
- m_data_req  in  1  from master data_req
- m_busy  in  1  from master busy
- ready  out  1  high when init is complete, no transaction is active and no refresh is pending
- frame_done  out  1  1-cycle pulse when the data transaction's STOP completes

Behaviour:
- Reset (rst_n low at a clk edge):
  - All state clears; state = PWRUP.
  - Every output is 0: m_data_in=0, fb_addr=0, ready=0.
  - Pending refresh clears and the power-up counter clears.
  - A reset mid-transaction abandons it with no STOP. The master shares the reset.
- Transaction kinds and byte index idx (11-bit):
  - idx0 is always 8'h78. idx1 is the control byte: 8'h00 for commands, 8'h40 for data.
  - INIT: idx2..26 = AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF. Last idx is 26.
  - WIN: idx2..7 = 21 00 7F 22 00 07. Last idx is 7.
  - DATA: idx2..1025 = fb_data for fb_addr = idx-2. Last idx = FB_BYTES+1 = 1025.
- States:
  - PWRUP: count POWERUP_CYCLES, then go to TSTART with kind=INIT.
  - TSTART: pulse m_start for 1 cycle, but only when m_busy=0. Go to TWAITB.
  - TWAITB: wait for m_busy=1 (the master raises it 1 cycle after start). Set idx=0, go to TBYTE.
  - TBYTE byte handshake:
    - Byte source: table bytes are available immediately.
    - DATA payload bytes: assert fb_rd with fb_addr=idx-2, then latch fb_data the next cycle into a holding register and set byte_ok.
    - Prefetch is allowed while waiting on m_data_req.
    - When m_data_req=1 and byte_ok=1: pulse m_data_valid for exactly 1 cycle with m_data_in = byte, and m_stop=1 in the same cycle iff idx == last. Clear byte_ok.
    - The next cycle is a guard: m_data_req has dropped. No second valid is issued until m_data_req is low then high again.
    - If this was not the last byte, increment idx.
    - After the last byte, go to TEND.
  - TEND: wait for m_busy=0.
    - INIT leads to IDLE.
    - WIN leads to TSTART with kind=DATA.
    - DATA pulses frame_done and goes to IDLE.
  - IDLE: ready=1 unless a refresh is pending. A pending refresh leads to TSTART with kind=WIN.
- Refresh:
  - A refresh pulse in any state other than IDLE sets a 1-deep pending flag. Further pulses merge into it.
  - In IDLE, a refresh pulse or a set pending flag starts WIN and clears the flag.
  - A refresh arriving in the same cycle the flag is consumed re-sets the flag.
- m_data_valid and m_stop are never high outside TBYTE. m_start is never high while m_busy=1.
- idx is 11 bits and never wraps; fb_addr is idx-2 truncated to 10 bits and spans 0..1023.
- Each transaction's bytes are strictly in order with no byte skipped or repeated. Exactly one m_stop per transaction, coincident with the last m_data_valid.

Test Plan:
- Reset, POWERUP_US=10, bus model with I2C master → the first m_start occurs 270 cycles after reset release. Decoded bus shows 78 00 AE … AF (27 bytes) with STOP; ready=1 afterwards.
- Refresh in IDLE, fb_data = fb_addr[7:0] → bus shows 78 00 21 00 7F 22 00 07 STOP, then 78 40 00 01 … FF 00 … (1026 bytes) STOP. frame_done pulses once; fb_addr covers 0..1023 in order.
- Refresh pulsed 3 times during the init transaction → after init, exactly one WIN+DATA pair is sent; ready=0 until frame_done.
- Master with m_data_req delayed 5 cycles per byte → no m_data_valid is issued while m_data_req=0, and no byte is duplicated; byte count is 1026.
- rst_n low for 1 cycle at DATA idx=500 → all outputs 0 the next cycle and the sequence restarts from PWRUP. The next decoded transaction is INIT.
- Refresh pulsed in the same cycle frame_done pulses → a second WIN+DATA pair follows immediately.

Source files
------------

// File: rtl/ssd1306_i2c_sequencer.sv
// Sequences the SSD1306 init, window-set and full-frame GDDRAM write transactions
// over a byte-oriented, write-only I2C master with a start/data_req/busy handshake.
module ssd1306_i2c_sequencer #(
    parameter int         CLK_FREQ   = 27_000_000,
    parameter int         POWERUP_US = 100_000,
    parameter logic [6:0] SLAVE_ADDR = 7'h3C,
    parameter int         FB_BYTES   = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       refresh,
    output logic [9:0] fb_addr,
    output logic       fb_rd,
    input  logic [7:0] fb_data,
    output logic       m_start,
    output logic       m_stop,
    output logic       m_data_valid,
    output logic [7:0] m_data_in,
    input  logic       m_data_req,
    input  logic       m_busy,
    output logic       ready,
    output logic       frame_done
);

    localparam int          POWERUP_CYCLES = CLK_FREQ / 1_000_000 * POWERUP_US;
    localparam logic [31:0] PWR_LAST  = (POWERUP_CYCLES > 0) ? 32'(POWERUP_CYCLES - 1) : 32'd0;
    localparam logic [10:0] INIT_LAST = 11'd26;
    localparam logic [10:0] WIN_LAST  = 11'd7;
    localparam logic [10:0] DATA_LAST = 11'(FB_BYTES + 1);

    typedef enum logic [2:0] {PWRUP, TSTART, TWAITB, TBYTE, TEND, IDLE} state_t;
    typedef enum logic [1:0] {K_INIT, K_WIN, K_DATA} kind_t;

    state_t      state_reg, state_next;
    kind_t       kind_reg, kind_next;
    logic [31:0] pwr_cnt_reg, pwr_cnt_next;
    logic [10:0] idx_reg, idx_next;
    logic        pend_reg, pend_next;
    logic        byte_ok_reg, byte_ok_next;
    logic        rd_wait_reg, rd_wait_next;
    logic        guard_reg, guard_next;
    logic [7:0]  hold_reg, hold_next;

    logic [7:0]  table_byte;
    logic [7:0]  cur_byte;
    logic [10:0] last_idx;
    logic        payload;
    logic        byte_avail;
    logic        issue;

    function automatic logic [7:0] init_byte(input logic [4:0] i);
        case (i)
            5'd0:  init_byte = 8'hAE;  5'd1:  init_byte = 8'hD5;  5'd2:  init_byte = 8'h80;
            5'd3:  init_byte = 8'hA8;  5'd4:  init_byte = 8'h3F;  5'd5:  init_byte = 8'hD3;
            5'd6:  init_byte = 8'h00;  5'd7:  init_byte = 8'h40;  5'd8:  init_byte = 8'h8D;
            5'd9:  init_byte = 8'h14;  5'd10: init_byte = 8'h20;  5'd11: init_byte = 8'h00;
            5'd12: init_byte = 8'hA1;  5'd13: init_byte = 8'hC8;  5'd14: init_byte = 8'hDA;
            5'd15: init_byte = 8'h12;  5'd16: init_byte = 8'h81;  5'd17: init_byte = 8'hCF;
            5'd18: init_byte = 8'hD9;  5'd19: init_byte = 8'hF1;  5'd20: init_byte = 8'hDB;
            5'd21: init_byte = 8'h40;  5'd22: init_byte = 8'hA4;  5'd23: init_byte = 8'hA6;
            5'd24: init_byte = 8'hAF;
            default: init_byte = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] win_byte(input logic [2:0] i);
        case (i)
            3'd0: win_byte = 8'h21;  3'd1: win_byte = 8'h00;  3'd2: win_byte = 8'h7F;
            3'd3: win_byte = 8'h22;  3'd4: win_byte = 8'h00;  3'd5: win_byte = 8'h07;
            default: win_byte = 8'h00;
        endcase
    endfunction

    always_comb begin
        table_byte = 8'h00;
        case (kind_reg)
            K_WIN:   last_idx = WIN_LAST;
            K_DATA:  last_idx = DATA_LAST;
            default: last_idx = INIT_LAST;
        endcase
        if (idx_reg == 11'd0)
            table_byte = {SLAVE_ADDR, 1'b0};
        else if (idx_reg == 11'd1)
            table_byte = (kind_reg == K_DATA) ? 8'h40 : 8'h00;
        else if (kind_reg == K_WIN)
            table_byte = win_byte(idx_reg[2:0] - 3'd2);
        else
            table_byte = init_byte(idx_reg[4:0] - 5'd2);
    end

    // Payload bytes come from the framebuffer via the holding register; everything else is immediate.
    assign payload    = (kind_reg == K_DATA) && (idx_reg >= 11'd2);
    assign cur_byte   = payload ? hold_reg : table_byte;
    assign byte_avail = payload ? byte_ok_reg : 1'b1;
    assign issue      = (state_reg == TBYTE) && m_data_req && byte_avail && !guard_reg;

    assign fb_rd        = (state_reg == TBYTE) && payload && !byte_ok_reg && !rd_wait_reg;
    assign fb_addr      = fb_rd ? (idx_reg[9:0] - 10'd2) : 10'd0;
    assign m_data_valid = issue;
    assign m_data_in    = issue ? cur_byte : 8'h00;
    assign m_stop       = issue && (idx_reg == last_idx);
    assign m_start      = (state_reg == TSTART) && !m_busy;
    assign ready        = (state_reg == IDLE) && !pend_reg;
    assign frame_done   = (state_reg == TEND) && (kind_reg == K_DATA) && !m_busy;

    always_comb begin
        state_next   = state_reg;
        kind_next    = kind_reg;
        pwr_cnt_next = pwr_cnt_reg;
        idx_next     = idx_reg;
        pend_next    = pend_reg;
        byte_ok_next = byte_ok_reg;
        rd_wait_next = rd_wait_reg;
        guard_next   = guard_reg;
        hold_next    = hold_reg;

        if (state_reg != IDLE && refresh)
            pend_next = 1'b1;

        if (rd_wait_reg) begin
            hold_next    = fb_data;
            byte_ok_next = 1'b1;
            rd_wait_next = 1'b0;
        end
        if (fb_rd)
            rd_wait_next = 1'b1;

        case (state_reg)
            PWRUP: begin
                if (pwr_cnt_reg == PWR_LAST) begin
                    state_next = TSTART;
                    kind_next  = K_INIT;
                end else begin
                    pwr_cnt_next = pwr_cnt_reg + 32'd1;
                end
            end
            TSTART: begin
                if (!m_busy)
                    state_next = TWAITB;
            end
            TWAITB: begin
                if (m_busy) begin
                    state_next   = TBYTE;
                    idx_next     = 11'd0;
                    byte_ok_next = 1'b0;
                    rd_wait_next = 1'b0;
                    guard_next   = 1'b0;
                end
            end
            TBYTE: begin
                // Hold off a second valid until data_req has been seen low once.
                if (guard_reg && !m_data_req)
                    guard_next = 1'b0;
                if (issue) begin
                    guard_next   = 1'b1;
                    byte_ok_next = 1'b0;
                    if (idx_reg == last_idx)
                        state_next = TEND;
                    else
                        idx_next = idx_reg + 11'd1;
                end
            end
            TEND: begin
                if (!m_busy) begin
                    case (kind_reg)
                        K_WIN: begin
                            state_next = TSTART;
                            kind_next  = K_DATA;
                        end
                        default: state_next = IDLE;
                    endcase
                end
            end
            IDLE: begin
                if (pend_reg || refresh) begin
                    state_next = TSTART;
                    kind_next  = K_WIN;
                    pend_next  = pend_reg && refresh;
                end
            end
            default: state_next = PWRUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= PWRUP;
            kind_reg    <= K_INIT;
            pwr_cnt_reg <= 32'd0;
            idx_reg     <= 11'd0;
            pend_reg    <= 1'b0;
            byte_ok_reg <= 1'b0;
            rd_wait_reg <= 1'b0;
            guard_reg   <= 1'b0;
            hold_reg    <= 8'h00;
        end else begin
            state_reg   <= state_next;
            kind_reg    <= kind_next;
            pwr_cnt_reg <= pwr_cnt_next;
            idx_reg     <= idx_next;
            pend_reg    <= pend_next;
            byte_ok_reg <= byte_ok_next;
            rd_wait_reg <= rd_wait_next;
            guard_reg   <= guard_next;
            hold_reg    <= hold_next;
        end
    end

endmodule

// File: tb/tb_ssd1306_i2c_sequencer.sv
// Bench for ssd1306_i2c_sequencer: behavioural I2C master + framebuffer RAM,
// transaction scoreboard built from the display command lists.
`timescale 1ns/1ps
module tb_ssd1306_i2c_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       refresh = 1'b0;
    logic [9:0] fb_addr;
    logic       fb_rd;
    logic [7:0] fb_data = 8'h00;
    logic       m_start, m_stop, m_data_valid;
    logic [7:0] m_data_in;
    logic       m_data_req = 1'b0;
    logic       m_busy = 1'b0;
    logic       ready, frame_done;

    always #5 clk = ~clk;

    ssd1306_i2c_sequencer #(
        .CLK_FREQ(27_000_000), .POWERUP_US(10), .SLAVE_ADDR(7'h3C), .FB_BYTES(1024)
    ) dut (
        .clk(clk), .rst_n(rst_n), .refresh(refresh),
        .fb_addr(fb_addr), .fb_rd(fb_rd), .fb_data(fb_data),
        .m_start(m_start), .m_stop(m_stop), .m_data_valid(m_data_valid), .m_data_in(m_data_in),
        .m_data_req(m_data_req), .m_busy(m_busy), .ready(ready), .frame_done(frame_done)
    );

    localparam logic [7:0] INIT_SEQ [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00,
        8'h40, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9,
        8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
    localparam logic [7:0] WIN_SEQ [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    typedef struct {
        int n_pulses;
        int gap;
        int req_delay;
        bit rand_delay;
        bit rand_fb;
        int exp_frames;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] fb_mem [1024];
    int         kind_q[$];     // 0 INIT, 1 WIN, 2 DATA
    logic [7:0] rx_q[$];
    int         phase = 0, cnt = 0, req_delay = 0;
    bit         rand_delay = 1'b0;
    int         cyc = 0, first_start = -1, frame_cnt = 0, txn_cnt = 0;
    int         fb_next = 0;
    bit         fb_bad = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    function automatic int next_delay();
        return rand_delay ? int'($urandom_range(0, req_delay)) : req_delay;
    endfunction

    task automatic compare_txn();
        int         k;
        int         n_bad;
        logic [7:0] exp_q[$];
        string      kname;
        if (kind_q.size() == 0) begin
            chk("unexpected_txn_len", 32'(rx_q.size()), 32'd0);
            return;
        end
        k = kind_q.pop_front();
        exp_q.push_back(8'h78);
        exp_q.push_back((k == 2) ? 8'h40 : 8'h00);
        if (k == 0)
            for (int i = 0; i < 25; i++) exp_q.push_back(INIT_SEQ[i]);
        else if (k == 1)
            for (int i = 0; i < 6; i++) exp_q.push_back(WIN_SEQ[i]);
        else
            for (int i = 0; i < 1024; i++) exp_q.push_back(fb_mem[i]);
        kname = (k == 0) ? "INIT" : (k == 1) ? "WIN" : "DATA";
        chk($sformatf("txn%0d_%s_len", txn_cnt, kname), 32'(rx_q.size()), 32'(exp_q.size()));
        n_bad = 0;
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            if (rx_q[i] !== exp_q[i]) n_bad++;
        chk($sformatf("txn%0d_%s_bad_bytes", txn_cnt, kname), 32'(n_bad), 32'd0);
        if (k == 2)
            chk($sformatf("txn%0d_fb_reads_in_order", txn_cnt),
                fb_bad ? 32'hFFFF_FFFF : 32'(fb_next), 32'd1024);
        $display("txn %0d kind %s bytes %0d first %02h last %02h", txn_cnt, kname, rx_q.size(),
                 (rx_q.size() > 0) ? rx_q[0] : 8'h00,
                 (rx_q.size() > 0) ? rx_q[rx_q.size()-1] : 8'h00);
        txn_cnt++;
    endtask

    // Registered master and RAM: sample at negedge, apply just after the next posedge.
    initial begin
        logic       nb, nr;
        logic [7:0] nfd;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cyc = 0; phase = 0; first_start = -1;
                m_busy = 1'b0; m_data_req = 1'b0; fb_data = 8'h00;
                rx_q.delete(); fb_next = 0; fb_bad = 1'b0;
                continue;
            end
            cyc++;
            nb = m_busy; nr = m_data_req; nfd = fb_data;
            if (fb_rd) begin
                if (fb_addr != 10'(fb_next)) fb_bad = 1'b1;
                fb_next++;
                nfd = fb_mem[fb_addr];
            end
            if (frame_done) frame_cnt++;
            if (m_start) begin
                chk("start_while_busy", 32'(m_busy), 32'd0);
                if (first_start < 0) first_start = cyc;
            end
            if (m_data_valid) chk("valid_without_req", 32'(m_data_req), 32'd1);
            if (m_stop) chk("stop_without_valid", 32'(m_data_valid), 32'd1);
            case (phase)
                0: if (m_start) begin
                    nb = 1'b1; phase = 1; cnt = next_delay();
                    rx_q.delete(); fb_next = 0; fb_bad = 1'b0;
                end
                1: if (cnt == 0) begin nr = 1'b1; phase = 2; end else cnt--;
                2: if (m_data_valid) begin
                    rx_q.push_back(m_data_in);
                    nr = 1'b0;
                    if (m_stop) begin phase = 3; cnt = 2; end
                    else begin phase = 1; cnt = next_delay(); end
                end
                default: if (cnt == 0) begin nb = 1'b0; phase = 0; compare_txn(); end else cnt--;
            endcase
            @(posedge clk);
            #1;
            m_busy = nb; m_data_req = nr; fb_data = nfd;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        step();
        refresh = 1'b0;
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget && !(kind_q.size() == 0 && phase == 0 && ready)) begin
            step();
            n++;
        end
        chk({name, "_quiet"}, 32'(n < budget), 32'd1);
    endtask

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   f0, n, rdy_hits;
        vecs[0] = '{1, 0,  0, 1'b0, 1'b0, 1};
        vecs[1] = '{1, 0,  5, 1'b0, 1'b1, 1};
        vecs[2] = '{2, 20, 3, 1'b1, 1'b1, 2};
        vecs[3] = '{3, 7,  1, 1'b0, 1'b1, 2};
        for (int i = 0; i < 1024; i++) fb_mem[i] = 8'(i);

        // Reset, power-up timing, and refreshes merged during INIT.
        repeat (3) step();
        chk("reset_outputs_zero", 32'({m_start, m_stop, m_data_valid, m_data_in, fb_addr,
                                        fb_rd, ready, frame_done}), 32'd0);
        kind_q.push_back(0);
        rst_n = 1'b1;
        n = 0;
        while (n < 400 && phase == 0) begin step(); n++; end
        chk("first_start_cycle", 32'(first_start), 32'd270);
        kind_q.push_back(1);
        kind_q.push_back(2);
        repeat (3) begin pulse_refresh(); repeat (4) step(); end
        rdy_hits = 0;
        n = 0;
        while (n < 8000 && frame_cnt == 0) begin
            if (ready) rdy_hits++;
            step();
            n++;
        end
        chk("ready_low_until_frame_done", 32'(rdy_hits), 32'd0);
        wait_quiet("init_merge", 4000);
        chk("init_merge_frames", 32'(frame_cnt), 32'd1);
        chk("ready_after_frame", 32'(ready), 32'd1);

        // Table-driven refresh scenarios with random bus timing and framebuffer contents.
        for (int v = 0; v < 4; v++) begin
            req_delay  = vecs[v].req_delay;
            rand_delay = vecs[v].rand_delay;
            for (int i = 0; i < 1024; i++)
                fb_mem[i] = vecs[v].rand_fb ? 8'($urandom) : 8'(i);
            f0 = frame_cnt;
            for (int p = 0; p < vecs[v].exp_frames; p++) begin
                kind_q.push_back(1);
                kind_q.push_back(2);
            end
            for (int p = 0; p < vecs[v].n_pulses; p++) begin
                pulse_refresh();
                repeat (vecs[v].gap) step();
            end
            wait_quiet($sformatf("vec%0d", v), 30000);
            chk($sformatf("vec%0d_frames", v), 32'(frame_cnt - f0), 32'(vecs[v].exp_frames));
            $display("vec %0d pulses %0d delay %0d frames %0d", v, vecs[v].n_pulses,
                     vecs[v].req_delay, frame_cnt - f0);
        end

        // Refresh coincident with frame_done chains a second pair.
        req_delay = 0; rand_delay = 1'b0;
        f0 = frame_cnt;
        repeat (2) begin kind_q.push_back(1); kind_q.push_back(2); end
        pulse_refresh();
        n = 0;
        while (n < 8000 && !frame_done) begin step(); n++; end
        chk("coincident_frame_done_seen", 32'(frame_done), 32'd1);
        pulse_refresh();
        wait_quiet("coincident", 8000);
        chk("coincident_frames", 32'(frame_cnt - f0), 32'd2);

        // Reset in the middle of a DATA stream restarts from power-up with INIT.
        kind_q.push_back(1);
        kind_q.push_back(2);
        pulse_refresh();
        n = 0;
        while (n < 8000 && !(kind_q.size() > 0 && kind_q[0] == 2 && rx_q.size() == 500)) begin
            step();
            n++;
        end
        chk("reached_data_idx500", 32'(rx_q.size()), 32'd500);
        f0 = frame_cnt;
        rst_n = 1'b0;
        step();
        chk("midframe_reset_outputs_zero", 32'({m_start, m_stop, m_data_valid, m_data_in,
                                                 fb_addr, fb_rd, ready, frame_done}), 32'd0);
        kind_q.delete();
        kind_q.push_back(0);
        rst_n = 1'b1;
        n = 0;
        while (n < 400 && phase == 0) begin step(); n++; end
        chk("restart_start_cycle", 32'(first_start), 32'd270);
        wait_quiet("restart_init", 4000);
        chk("restart_no_frame", 32'(frame_cnt - f0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
